// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the 10-bit-command SPI RAM: frame deserialiser, read-address/read-data
// ordering and MISO serialiser. Define SPI_CTRL_RD_TIMEOUT_EN to bound the wait for RAM read data.
module spi_slave_ctrl #(
  parameter int FRAME_W    = 10,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int CNT_W    = $clog2(FRAME_W);
  localparam int TX_CNT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [TX_CNT_W-1:0] TX_ZERO  = {TX_CNT_W{1'b0}};
  localparam logic [TX_CNT_W-1:0] TX_ONE   = {{(TX_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TX_CNT_W-1:0] TX_LAST  = TX_CNT_W'(DATA_W - 1);

  if (FRAME_W < 3 || DATA_W < 2 || RD_TIMEOUT < 1) begin : g_param_check
    $error("spi_slave_ctrl: FRAME_W >= 3, DATA_W >= 2 and RD_TIMEOUT >= 1 are required");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e              state_r;
  logic [FRAME_W-2:0]  frame_sr_r;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [FRAME_W-1:0]  rx_data_r;
  logic                rx_valid_r;
  logic                rd_addr_seen_r;
  logic [DATA_W-1:0]   tx_sr_r;
  logic [TX_CNT_W-1:0] tx_cnt_r;
  logic                tx_busy_r;
  logic                tx_done_r;
  logic                miso_r;
  logic                tx_wait_s;

`ifdef SPI_CTRL_RD_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_cnt_r;
`endif

  // Read data is only accepted once the frame is in and its rx_valid pulse has passed.
  always_comb begin
    tx_wait_s = (state_r == READ_DATA) && (bit_cnt_r == CNT_ZERO) && !rx_valid_r &&
                !tx_busy_r && !tx_done_r;
  end

  // Transaction sequencer: frame capture, read ordering and MISO serialisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      frame_sr_r     <= {(FRAME_W-1){1'b0}};
      bit_cnt_r      <= CNT_ZERO;
      rx_data_r      <= {FRAME_W{1'b0}};
      rx_valid_r     <= 1'b0;
      rd_addr_seen_r <= 1'b0;
      tx_sr_r        <= {DATA_W{1'b0}};
      tx_cnt_r       <= TX_ZERO;
      tx_busy_r      <= 1'b0;
      tx_done_r      <= 1'b0;
      miso_r         <= 1'b0;
`ifdef SPI_CTRL_RD_TIMEOUT_EN
      wait_cnt_r     <= WAIT_ZERO;
`endif
    end else begin
      rx_valid_r <= 1'b0;
      if (SS_n) begin
        // Abort/end: rd_addr_seen is deliberately kept so an interrupted read retries.
        state_r   <= IDLE;
        bit_cnt_r <= CNT_ZERO;
        tx_cnt_r  <= TX_ZERO;
        tx_busy_r <= 1'b0;
        tx_done_r <= 1'b0;
        miso_r    <= 1'b0;
`ifdef SPI_CTRL_RD_TIMEOUT_EN
        wait_cnt_r <= WAIT_ZERO;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= CHK_CMD;
          end
          CHK_CMD: begin
            frame_sr_r <= {{(FRAME_W-2){1'b0}}, MOSI};
            bit_cnt_r  <= CNT_LAST;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
`ifdef SPI_CTRL_RD_TIMEOUT_EN
            wait_cnt_r <= WAIT_ZERO;
`endif
            if (!MOSI) begin
              state_r <= WRITE;
            end else if (rd_addr_seen_r) begin
              state_r <= READ_DATA;
            end else begin
              state_r <= READ_ADD;
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt_r != CNT_ZERO) begin
              frame_sr_r <= {frame_sr_r[FRAME_W-3:0], MOSI};
              bit_cnt_r  <= bit_cnt_r - CNT_ONE;
              if (bit_cnt_r == CNT_ONE) begin
                rx_data_r  <= {frame_sr_r, MOSI};
                rx_valid_r <= 1'b1;
                if (state_r == READ_ADD) begin
                  rd_addr_seen_r <= 1'b1;
                end
              end
            end else if (state_r == READ_DATA) begin
              if (tx_busy_r) begin
                if (tx_cnt_r != TX_ZERO) begin
                  miso_r   <= tx_sr_r[DATA_W-1];
                  tx_sr_r  <= {tx_sr_r[DATA_W-2:0], 1'b0};
                  tx_cnt_r <= tx_cnt_r - TX_ONE;
                end else begin
                  miso_r    <= 1'b0;
                  tx_busy_r <= 1'b0;
                  tx_done_r <= 1'b1;
                end
              end else if (tx_wait_s && tx_valid) begin
                // MSB goes out straight from tx_data; the rest shifts from tx_sr_r.
                miso_r         <= tx_data[DATA_W-1];
                tx_sr_r        <= {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt_r       <= TX_LAST;
                tx_busy_r      <= 1'b1;
                rd_addr_seen_r <= 1'b0;
`ifdef SPI_CTRL_RD_TIMEOUT_EN
              end else if (tx_wait_s) begin
                if (wait_cnt_r == WAIT_LAST) begin
                  tx_done_r      <= 1'b1;
                  rd_addr_seen_r <= 1'b0;
                end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                end
`endif
              end
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign MISO     = miso_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;

endmodule
